multibuf_ctrl: RTL and testbench

MULTIBUF_CTRL -- requirements
Module: multibuf_ctrl

---
 rtl/multibuf_ctrl_pkg.sv | 25 ++
 rtl/multibuf_side_fsm.sv | 73 +++++++
 rtl/multibuf_ctrl.sv | 111 +++++++++++
 tb/tb_multibuf_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/multibuf_ctrl_pkg.sv
// Shared types and defaults for the rotating multi-buffer controller.
// Buffer states, side FSM states and width helpers live here.
package multibuf_ctrl_pkg;

   localparam int N_BUF_DEFAULT    = 2;
   localparam int BUF_SIZE_DEFAULT = 8192;

   typedef enum logic [1:0] {
      BUF_EMPTY    = 2'd0,
      BUF_FILLING  = 2'd1,
      BUF_FULL     = 2'd2,
      BUF_DRAINING = 2'd3
   } buf_state_t;

   typedef enum logic {
      SIDE_IDLE = 1'b0,
      SIDE_OWN  = 1'b1
   } side_state_t;

   // A two-buffer ring still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multibuf_side_fsm.sv
// One side (producer or consumer) of the buffer ring: IDLE/OWN FSM,
// ring pointer and grant. The top applies the buffer-state writes it requests.
module multibuf_side_fsm
   import multibuf_ctrl_pkg::*;
#(
   parameter int         N_BUF       = N_BUF_DEFAULT,
   parameter buf_state_t REQ_STATE   = BUF_EMPTY,
   parameter buf_state_t CLAIM_STATE = BUF_FILLING,
   parameter buf_state_t DONE_STATE  = BUF_FULL,
   localparam int        IDX_W       = idx_width(N_BUF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             acquire,
   input  logic             rel,
   input  logic [1:0]       cur_state,
   output logic             grant,
   output logic [IDX_W-1:0] ptr,
   output logic             wr_en,
   output logic [1:0]       wr_state,
   output logic             bad_rel,
   output logic             fsm_state
);

   // Handshake: acquire is a level request held by the requester until
   // grant rises one cycle after buffer[ptr] is seen in REQ_STATE; grant stays
   // high until the cycle after rel. rel without grant is a protocol error.
   side_state_t      state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q <= SIDE_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wr_en    = 1'b0;
      wr_state = CLAIM_STATE;
      bad_rel  = 1'b0;
      case (state_q)
         SIDE_IDLE: begin
            if (acquire && (cur_state == REQ_STATE)) begin
               wr_en    = 1'b1;
               wr_state = CLAIM_STATE;
               state_d  = SIDE_OWN;
            end
            if (rel) bad_rel = 1'b1;
         end
         SIDE_OWN: begin
            if (rel) begin
               wr_en    = 1'b1;
               wr_state = DONE_STATE;
               ptr_d    = (ptr_q == IDX_W'(N_BUF - 1)) ? '0 : ptr_q + 1'b1;
               state_d  = SIDE_IDLE;
            end
         end
         default: state_d = SIDE_IDLE;
      endcase
   end

   assign grant     = (state_q == SIDE_OWN);
   assign ptr       = ptr_q;
   assign fsm_state = state_q;

endmodule

// File: rtl/multibuf_ctrl.sv
// Rotating multi-buffer controller: producer fills, consumer drains, buffers
// cycle EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY in ring order.
module multibuf_ctrl
   import multibuf_ctrl_pkg::*;
#(
   parameter int  N_BUF    = N_BUF_DEFAULT,
   parameter int  BUF_SIZE = BUF_SIZE_DEFAULT,
   localparam int IDX_W    = idx_width(N_BUF),
   localparam int LA_W     = $clog2(BUF_SIZE),
   localparam int PA_W     = $clog2(N_BUF * BUF_SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             prod_acquire,
   input  logic             prod_release,
   output logic             prod_grant,
   output logic [IDX_W-1:0] prod_buf_idx,
   input  logic [LA_W-1:0]  prod_local_addr,
   output logic [PA_W-1:0]  prod_phys_addr,
   input  logic             cons_acquire,
   input  logic             cons_release,
   output logic             cons_grant,
   output logic [IDX_W-1:0] cons_buf_idx,
   input  logic [LA_W-1:0]  cons_local_addr,
   output logic [PA_W-1:0]  cons_phys_addr,
   output logic [IDX_W:0]   full_count,
   output logic             all_empty,
   output logic             proto_err
);

   buf_state_t       buf_q [N_BUF];
   buf_state_t       buf_d [N_BUF];
   logic [IDX_W:0]   full_d;
   logic             empty_d;

   logic [IDX_W-1:0] p_ptr, c_ptr;
   logic             p_wr_en, c_wr_en, p_bad, c_bad, p_state, c_state;
   logic [1:0]       p_wr_state, c_wr_state;

   multibuf_side_fsm #(
      .N_BUF(N_BUF), .REQ_STATE(BUF_EMPTY),
      .CLAIM_STATE(BUF_FILLING), .DONE_STATE(BUF_FULL)
   ) u_prod (
      .clk(clk), .reset(reset), .flush(flush),
      .acquire(prod_acquire), .rel(prod_release),
      .cur_state(buf_q[p_ptr]),
      .grant(prod_grant), .ptr(p_ptr),
      .wr_en(p_wr_en), .wr_state(p_wr_state),
      .bad_rel(p_bad), .fsm_state(p_state)
   );

   multibuf_side_fsm #(
      .N_BUF(N_BUF), .REQ_STATE(BUF_FULL),
      .CLAIM_STATE(BUF_DRAINING), .DONE_STATE(BUF_EMPTY)
   ) u_cons (
      .clk(clk), .reset(reset), .flush(flush),
      .acquire(cons_acquire), .rel(cons_release),
      .cur_state(buf_q[c_ptr]),
      .grant(cons_grant), .ptr(c_ptr),
      .wr_en(c_wr_en), .wr_state(c_wr_state),
      .bad_rel(c_bad), .fsm_state(c_state)
   );

   // The two sides never write the same buffer: each only touches a buffer
   // in the state the other side has just handed over.
   always_comb begin
      buf_d = buf_q;
      if (flush) begin
         for (int i = 0; i < N_BUF; i++) buf_d[i] = BUF_EMPTY;
      end else begin
         if (p_wr_en) buf_d[p_ptr] = buf_state_t'(p_wr_state);
         if (c_wr_en) buf_d[c_ptr] = buf_state_t'(c_wr_state);
      end
   end

   always_comb begin
      full_d  = '0;
      empty_d = 1'b1;
      for (int i = 0; i < N_BUF; i++) begin
         if (buf_d[i] == BUF_FULL)  full_d  = full_d + (IDX_W+1)'(1);
         if (buf_d[i] != BUF_EMPTY) empty_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_BUF; i++) buf_q[i] <= BUF_EMPTY;
         full_count <= '0;
         all_empty  <= 1'b1;
         proto_err  <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         full_count <= full_d;
         all_empty  <= empty_d;
         if (!flush && (p_bad || c_bad)) proto_err <= 1'b1;
      end
   end

   assign prod_phys_addr = {prod_buf_idx, prod_local_addr};
   assign cons_phys_addr = {cons_buf_idx, cons_local_addr};
   assign prod_buf_idx   = p_ptr;
   assign cons_buf_idx   = c_ptr;

   // Ownership must always match the state of the owned buffer.
   a_prod_own: assert property (@(posedge clk) disable iff (reset)
      (p_state == SIDE_OWN) == (buf_q[p_ptr] == BUF_FILLING));
   a_cons_own: assert property (@(posedge clk) disable iff (reset)
      (c_state == SIDE_OWN) == (buf_q[c_ptr] == BUF_DRAINING));

endmodule

// File: tb/tb_multibuf_ctrl.sv
// Directed bench for multibuf_ctrl: a vector table for the ring walk on a
// two-buffer instance, plus hand sequences on two- and four-buffer instances.
module tb_multibuf_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, prod_acquire, prod_release, cons_acquire, cons_release;
   logic        prod_grant, cons_grant, all_empty, proto_err;
   logic        prod_buf_idx, cons_buf_idx;
   logic [12:0] prod_local_addr, cons_local_addr;
   logic [13:0] prod_phys_addr, cons_phys_addr;
   logic [1:0]  full_count;

   logic        flush4, pa4, pr4, ca4, cr4, pg4, cg4, ae4, pe4;
   logic [1:0]  pidx4, cidx4;
   logic [12:0] pla4, cla4;
   logic [14:0] pp4, cp4;
   logic [2:0]  fc4;

   multibuf_ctrl #(.N_BUF(2), .BUF_SIZE(8192)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .prod_acquire(prod_acquire), .prod_release(prod_release),
      .prod_grant(prod_grant), .prod_buf_idx(prod_buf_idx),
      .prod_local_addr(prod_local_addr), .prod_phys_addr(prod_phys_addr),
      .cons_acquire(cons_acquire), .cons_release(cons_release),
      .cons_grant(cons_grant), .cons_buf_idx(cons_buf_idx),
      .cons_local_addr(cons_local_addr), .cons_phys_addr(cons_phys_addr),
      .full_count(full_count), .all_empty(all_empty), .proto_err(proto_err)
   );

   multibuf_ctrl #(.N_BUF(4), .BUF_SIZE(8192)) dut4 (
      .clk(clk), .reset(reset), .flush(flush4),
      .prod_acquire(pa4), .prod_release(pr4),
      .prod_grant(pg4), .prod_buf_idx(pidx4),
      .prod_local_addr(pla4), .prod_phys_addr(pp4),
      .cons_acquire(ca4), .cons_release(cr4),
      .cons_grant(cg4), .cons_buf_idx(cidx4),
      .cons_local_addr(cla4), .cons_phys_addr(cp4),
      .full_count(fc4), .all_empty(ae4), .proto_err(pe4)
   );

   typedef struct {
      logic        flush, pa, pr;
      logic [12:0] pla;
      logic        ca, cr;
      logic [12:0] cla;
      logic        pg, pidx;
      logic [13:0] pp;
      logic        cg, cidx;
      logic [13:0] cp;
      logic [1:0]  fc;
      logic        ae, pe;
   } vec_t;

   vec_t vecs[17];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(
      input logic fl, input logic pa, input logic pr, input logic [12:0] pla,
      input logic ca, input logic cr, input logic [12:0] cla,
      input logic pg, input logic pidx, input logic [13:0] pp,
      input logic cg, input logic cidx, input logic [13:0] cp,
      input logic [1:0] fc, input logic ae, input logic pe);
      vec_t v;
      v.flush = fl; v.pa = pa; v.pr = pr; v.pla = pla;
      v.ca = ca; v.cr = cr; v.cla = cla;
      v.pg = pg; v.pidx = pidx; v.pp = pp;
      v.cg = cg; v.cidx = cidx; v.cp = cp;
      v.fc = fc; v.ae = ae; v.pe = pe;
      return v;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; prod_acquire = 0; prod_release = 0;
      cons_acquire = 0; cons_release = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      prod_local_addr = '0; cons_local_addr = 13'd7;
      flush4 = 0; pa4 = 0; pr4 = 0; ca4 = 0; cr4 = 0; pla4 = '0; cla4 = '0;

      //            fl pa pr pla ca cr cla | pg pidx pp   cg cidx cp  fc ae pe
      vecs[0]  = mk(0, 1, 0, 5,  0, 0, 7,    1, 0, 5,     0, 0, 7,    0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 5,  0, 0, 7,    1, 0, 5,     0, 0, 7,    0, 0, 0);
      vecs[2]  = mk(0, 0, 1, 3,  0, 0, 7,    0, 1, 8195,  0, 0, 7,    1, 0, 0);
      vecs[3]  = mk(0, 1, 0, 3,  0, 0, 7,    1, 1, 8195,  0, 0, 7,    1, 0, 0);
      vecs[4]  = mk(0, 0, 1, 3,  0, 0, 7,    0, 0, 3,     0, 0, 7,    2, 0, 0);
      vecs[5]  = mk(0, 1, 0, 3,  0, 0, 7,    0, 0, 3,     0, 0, 7,    2, 0, 0);
      vecs[6]  = mk(0, 1, 0, 3,  0, 0, 7,    0, 0, 3,     0, 0, 7,    2, 0, 0);
      vecs[7]  = mk(0, 1, 0, 3,  1, 0, 7,    0, 0, 3,     1, 0, 7,    1, 0, 0);
      vecs[8]  = mk(0, 1, 0, 3,  1, 0, 7,    0, 0, 3,     1, 0, 7,    1, 0, 0);
      vecs[9]  = mk(0, 1, 0, 3,  0, 1, 7,    0, 0, 3,     0, 1, 8199, 1, 0, 0);
      vecs[10] = mk(0, 1, 0, 3,  0, 0, 7,    1, 0, 3,     0, 1, 8199, 1, 0, 0);
      vecs[11] = mk(0, 0, 0, 3,  1, 0, 7,    1, 0, 3,     1, 1, 8199, 0, 0, 0);
      vecs[12] = mk(0, 0, 1, 3,  0, 1, 7,    0, 1, 8195,  0, 0, 7,    1, 0, 0);
      vecs[13] = mk(0, 1, 0, 3,  1, 0, 7,    1, 1, 8195,  1, 0, 7,    0, 0, 0);
      vecs[14] = mk(0, 0, 1, 3,  0, 1, 7,    0, 0, 3,     0, 1, 8199, 1, 0, 0);
      vecs[15] = mk(0, 0, 0, 3,  0, 1, 7,    0, 0, 3,     0, 1, 8199, 1, 0, 1);
      vecs[16] = mk(1, 0, 0, 3,  0, 0, 7,    0, 0, 3,     0, 0, 7,    0, 1, 1);

      tick(); tick();
      chk("rst_prod_grant", prod_grant, 0);
      chk("rst_cons_grant", cons_grant, 0);
      chk("rst_prod_idx", prod_buf_idx, 0);
      chk("rst_full_count", full_count, 0);
      chk("rst_all_empty", all_empty, 1);
      chk("rst_proto_err", proto_err, 0);
      reset = 0;

      for (int i = 0; i < 17; i++) begin
         flush = vecs[i].flush;
         prod_acquire = vecs[i].pa; prod_release = vecs[i].pr;
         prod_local_addr = vecs[i].pla;
         cons_acquire = vecs[i].ca; cons_release = vecs[i].cr;
         cons_local_addr = vecs[i].cla;
         tick();
         chk($sformatf("v%0d_prod_grant", i), prod_grant, vecs[i].pg);
         chk($sformatf("v%0d_prod_idx", i), prod_buf_idx, vecs[i].pidx);
         chk($sformatf("v%0d_prod_phys", i), prod_phys_addr, vecs[i].pp);
         chk($sformatf("v%0d_cons_grant", i), cons_grant, vecs[i].cg);
         chk($sformatf("v%0d_cons_idx", i), cons_buf_idx, vecs[i].cidx);
         chk($sformatf("v%0d_cons_phys", i), cons_phys_addr, vecs[i].cp);
         chk($sformatf("v%0d_full_count", i), full_count, vecs[i].fc);
         chk($sformatf("v%0d_all_empty", i), all_empty, vecs[i].ae);
         chk($sformatf("v%0d_proto_err", i), proto_err, vecs[i].pe);
      end

      // Release-to-acquire latency: consumer holds acquire across the release.
      idle_inputs();
      cons_acquire = 1; prod_acquire = 1;
      tick();
      chk("lat_prod_grant", prod_grant, 1);
      chk("lat_cons_wait0", cons_grant, 0);
      prod_acquire = 0; prod_release = 1;
      tick();
      chk("lat_prod_drop", prod_grant, 0);
      chk("lat_cons_wait1", cons_grant, 0);
      chk("lat_full_count", full_count, 1);
      prod_release = 0;
      tick();
      chk("lat_cons_grant", cons_grant, 1);
      chk("lat_cons_idx", cons_buf_idx, 0);
      chk("lat_full_after", full_count, 0);
      cons_acquire = 0; cons_release = 1;
      tick();
      chk("lat_cons_drop", cons_grant, 0);
      chk("lat_all_empty", all_empty, 1);

      // Sticky error: set by idle prod_release, survives flush, cleared by reset.
      idle_inputs(); reset = 1;
      tick();
      chk("err_rst_clear", proto_err, 0);
      reset = 0; prod_release = 1;
      tick();
      chk("err_set", proto_err, 1);
      chk("err_no_grant", prod_grant, 0);
      chk("err_no_full", full_count, 0);
      prod_release = 0; flush = 1;
      tick();
      chk("err_flush_keep", proto_err, 1);
      flush = 0; reset = 1;
      tick();
      chk("err_reset_clear", proto_err, 0);
      reset = 0;

      // Four-buffer instance: flush while both sides own buffers.
      pa4 = 1;
      tick();
      chk("n4_prod_grant", pg4, 1);
      chk("n4_prod_idx0", pidx4, 0);
      pa4 = 0; pr4 = 1;
      tick();
      chk("n4_prod_drop", pg4, 0);
      chk("n4_prod_idx1", pidx4, 1);
      chk("n4_full1", fc4, 1);
      pr4 = 0; pa4 = 1; ca4 = 1;
      tick();
      chk("n4_prod_own1", pg4, 1);
      chk("n4_cons_own0", cg4, 1);
      chk("n4_full0", fc4, 0);
      flush4 = 1;
      tick();
      chk("n4_flush_empty", ae4, 1);
      chk("n4_flush_pg", pg4, 0);
      chk("n4_flush_cg", cg4, 0);
      chk("n4_flush_pidx", pidx4, 0);
      chk("n4_flush_cidx", cidx4, 0);
      flush4 = 0; ca4 = 0; pla4 = 13'd2;
      tick();
      chk("n4_regrant", pg4, 1);
      chk("n4_regrant_idx", pidx4, 0);
      chk("n4_regrant_phys", pp4, 2);
      chk("n4_cons_phys", cp4, 0);
      chk("n4_proto_err", pe4, 0);
      pa4 = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
